// File: rtl/imem_loader_arb.sv
// imem_loader_arb: streams a program image into the instruction memory over a
// valid/ready word interface, stalls the pipeline until a load has completed,
// then arbitrates fetch-stage read access to the memory.
module imem_loader_arb #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  // program source
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic [AW:0]   load_count,
  // memory write port
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  // fetch stage and memory read port
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   fetch_instr,
  output logic          fetch_gnt,
  output logic          cpu_stall,
  output logic          fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_t      state_q;
  logic [AW:0] len_q;
  logic [AW:0] count_q;
  logic [AW:0] count_d;
  logic        done_q;
  logic        err_q;

  logic [AW:0] len_clamped;
  logic        handshake;
  logic        in_run;
  logic        aligned;
  logic        in_range;
  logic        fetch_ok;

  // Oversized load requests are limited to the memory depth.
  assign len_clamped = (load_len > DEPTH_W) ? DEPTH_W : load_len;

  assign handshake = (state_q == LOAD) && load_valid;
  assign count_d   = count_q + ONE_W;
  assign in_run    = (state_q == RUN);

  // Word-aligned and inside the memory window; upper address bits must be zero.
  assign aligned  = (fetch_addr[1:0] == 2'b00);
  assign in_range = (fetch_addr[31:AW+2] == '0);
  assign fetch_ok = aligned && in_range;

  // Combinational decodes: the memory captures the write on the handshake edge,
  // and reset forces the state to IDLE so mem_we drops without waiting for a clock.
  assign load_ready  = (state_q == LOAD);
  assign mem_we      = handshake;
  assign mem_waddr   = count_q[AW-1:0];
  assign mem_wdata   = load_data;
  assign mem_raddr   = fetch_addr[AW+1:2];
  assign fetch_gnt   = in_run && fetch_req && fetch_ok;
  assign fetch_instr = fetch_gnt ? mem_rdata : 32'd0;
  assign cpu_stall   = !in_run;
  assign load_done   = done_q;
  assign load_count  = count_q;
  assign fetch_err   = err_q;

  // Load/run sequencer with registered done pulse, word count and sticky fetch error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            len_q   <= len_clamped;
            count_q <= '0;
            err_q   <= 1'b0;
            if (len_clamped == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          // load_start is deliberately not looked at here.
          if (handshake) begin
            count_q <= count_d;
            if (count_d == len_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= RUN;
        end
        RUN: begin
          // A reload takes priority over flagging a bad fetch in the same cycle.
          if (load_start) begin
            len_q   <= len_clamped;
            count_q <= '0;
            err_q   <= 1'b0;
            if (len_clamped == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end else if (fetch_req && !fetch_ok) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
